// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port arbiter in front of a single-port RAM. Each access runs
//           SETUP -> STROBE -> CAPTURE. Define ARB_ROUND_ROBIN_EN to select
//           round-robin arbitration; the default is fixed priority to port 1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_we,
    input  logic                  p1_we,
    input  logic [ADDR_SPACE-1:0] p0_addr,
    input  logic [ADDR_SPACE-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_done,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_SPACE-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_datain,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_dataout,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                r_state_q,      w_state_d;
    logic [ADDR_SPACE-1:0] r_mem_addr_q,   w_mem_addr_d;
    logic [DATA_WIDTH-1:0] r_mem_datain_q, w_mem_datain_d;
    logic                  r_mem_read_q,   w_mem_read_d;
    logic                  r_mem_write_q,  w_mem_write_d;
    logic                  r_mem_enable_q, w_mem_enable_d;
    logic                  r_p0_done_q,    w_p0_done_d;
    logic                  r_p1_done_q,    w_p1_done_d;
    logic [DATA_WIDTH-1:0] r_p0_rdata_q,   w_p0_rdata_d;
    logic [DATA_WIDTH-1:0] r_p1_rdata_q,   w_p1_rdata_d;
    logic                  r_busy_q,       w_busy_d;
    logic                  r_grant_q,      w_grant_d;

    logic                  w_arb;
    logic                  w_pick;

    assign w_arb = ((r_state_q == S_IDLE) || (r_state_q == S_CAPTURE)) &&
                   (p0_req || p1_req);

`ifdef ARB_ROUND_ROBIN_EN
    // Last granted port; reset to 1 so port 0 wins the first tie.
    logic r_last_q, w_last_d;

    always_comb begin
        w_pick   = p1_req;
        w_last_d = r_last_q;
        if (p0_req && p1_req) begin
            w_pick = ~r_last_q;
        end
        if (w_arb) begin
            w_last_d = w_pick;
        end
    end
`else
    assign w_pick = p1_req;
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_datain_d = r_mem_datain_q;
        w_mem_read_d   = r_mem_read_q;
        w_mem_write_d  = r_mem_write_q;
        w_mem_enable_d = 1'b0;
        w_p0_done_d    = 1'b0;
        w_p1_done_d    = 1'b0;
        w_p0_rdata_d   = r_p0_rdata_q;
        w_p1_rdata_d   = r_p1_rdata_q;
        w_busy_d       = r_busy_q;
        w_grant_d      = r_grant_q;

        case (r_state_q)
            S_IDLE, S_CAPTURE: begin
                if (w_arb) begin
                    w_state_d      = S_SETUP;
                    w_grant_d      = w_pick;
                    w_mem_addr_d   = w_pick ? p1_addr  : p0_addr;
                    w_mem_datain_d = w_pick ? p1_wdata : p0_wdata;
                    w_mem_write_d  = w_pick ? p1_we    : p0_we;
                    w_mem_read_d   = w_pick ? ~p1_we   : ~p0_we;
                    w_busy_d       = 1'b1;
                end else begin
                    w_state_d     = S_IDLE;
                    w_mem_read_d  = 1'b0;
                    w_mem_write_d = 1'b0;
                    w_busy_d      = 1'b0;
                end
            end
            S_SETUP: begin
                w_state_d      = S_STROBE;
                w_mem_enable_d = 1'b1;
            end
            S_STROBE: begin
                // RAM data is valid while the strobe is high; capture it here.
                w_state_d = S_CAPTURE;
                if (r_grant_q) begin
                    w_p1_done_d = 1'b1;
                    if (r_mem_read_q) begin
                        w_p1_rdata_d = mem_dataout;
                    end
                end else begin
                    w_p0_done_d = 1'b1;
                    if (r_mem_read_q) begin
                        w_p0_rdata_d = mem_dataout;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state_q      <= S_IDLE;
            r_mem_addr_q   <= '0;
            r_mem_datain_q <= '0;
            r_mem_read_q   <= 1'b0;
            r_mem_write_q  <= 1'b0;
            r_mem_enable_q <= 1'b0;
            r_p0_done_q    <= 1'b0;
            r_p1_done_q    <= 1'b0;
            r_p0_rdata_q   <= '0;
            r_p1_rdata_q   <= '0;
            r_busy_q       <= 1'b0;
            r_grant_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_q       <= 1'b1;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_datain_q <= w_mem_datain_d;
            r_mem_read_q   <= w_mem_read_d;
            r_mem_write_q  <= w_mem_write_d;
            r_mem_enable_q <= w_mem_enable_d;
            r_p0_done_q    <= w_p0_done_d;
            r_p1_done_q    <= w_p1_done_d;
            r_p0_rdata_q   <= w_p0_rdata_d;
            r_p1_rdata_q   <= w_p1_rdata_d;
            r_busy_q       <= w_busy_d;
            r_grant_q      <= w_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_q       <= w_last_d;
`endif
        end
    end

    assign mem_addr   = r_mem_addr_q;
    assign mem_datain = r_mem_datain_q;
    assign mem_read   = r_mem_read_q;
    assign mem_write  = r_mem_write_q;
    assign mem_enable = r_mem_enable_q;
    assign p0_done    = r_p0_done_q;
    assign p1_done    = r_p1_done_q;
    assign p0_rdata   = r_p0_rdata_q;
    assign p1_rdata   = r_p1_rdata_q;
    assign busy       = r_busy_q;
    assign grant      = r_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter with a RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;
    logic        mem_read, mem_write, mem_enable;
    logic        busy, grant;

    logic [31:0] ram [0:511];

    int total  = 0;
    int bad    = 0;
    int en_cnt = 0;
    bit mon_on = 1'b0;
    bit prev_en = 1'b0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_SPACE(9)) dut (
        .clk        (clk),
        .clr        (clr),
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .p0_we      (p0_we),
        .p1_we      (p1_we),
        .p0_addr    (p0_addr),
        .p1_addr    (p1_addr),
        .p0_wdata   (p0_wdata),
        .p1_wdata   (p1_wdata),
        .p0_done    (p0_done),
        .p1_done    (p1_done),
        .p0_rdata   (p0_rdata),
        .p1_rdata   (p1_rdata),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_enable (mem_enable),
        .mem_dataout(mem_dataout),
        .busy       (busy),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataout = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_enable && mem_write) ram[mem_addr] <= mem_datain;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            assert ((mem_read & mem_write) === 1'b0) else begin
                bad++;
                $error("FAIL rw_excl: observed read=%b write=%b expected not both", mem_read, mem_write);
            end
            total++;
            assert (!(mem_enable === 1'b1 && prev_en)) else begin
                bad++;
                $error("FAIL en_pulse: observed enable high 2 cycles expected 1 cycle");
            end
            prev_en = (mem_enable === 1'b1);
            if (prev_en) en_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int fp;
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[0]      = 32'h1111_0000;
        ram[1]      = 32'h1111_0001;
        ram[2]      = 32'h1111_0002;
        ram[3]      = 32'h1111_0003;
        ram[5]      = 32'h5555_AAAA;
        ram[9'h1FF] = 32'hFFFF_01FF;

        clr = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        p0_addr = 9'h0; p1_addr = 9'h0; p0_wdata = 32'h0; p1_wdata = 32'h0;

        // Reset state
        step(); step();
        chk("rst_busy",   32'(busy),       32'h0);
        chk("rst_grant",  32'(grant),      32'h0);
        chk("rst_en",     32'(mem_enable), 32'h0);
        chk("rst_rd",     32'(mem_read),   32'h0);
        chk("rst_wr",     32'(mem_write),  32'h0);
        chk("rst_addr",   32'(mem_addr),   32'h0);
        chk("rst_p0done", 32'(p0_done),    32'h0);
        chk("rst_p1done", 32'(p1_done),    32'h0);
        chk("rst_p0rd",   p0_rdata,        32'h0);
        clr = 1'b0;
        mon_on = 1'b1;

        // Port 0 write 0x010 = DEADBEEF
        p0_we = 1'b1; p0_addr = 9'h010; p0_wdata = 32'hDEAD_BEEF; p0_req = 1'b1;
        step();
        p0_req = 1'b0;
        chk("w_setup_busy", 32'(busy),       32'h1);
        chk("w_setup_en",   32'(mem_enable), 32'h0);
        chk("w_setup_wr",   32'(mem_write),  32'h1);
        chk("w_setup_rd",   32'(mem_read),   32'h0);
        chk("w_setup_addr", 32'(mem_addr),   32'h010);
        chk("w_setup_din",  mem_datain,      32'hDEAD_BEEF);
        chk("w_setup_done", 32'(p0_done),    32'h0);
        step();
        chk("w_strobe_en",  32'(mem_enable), 32'h1);
        chk("w_strobe_done",32'(p0_done),    32'h0);
        step();
        chk("w_cap_done",   32'(p0_done),    32'h1);
        chk("w_cap_en",     32'(mem_enable), 32'h0);
        step();
        chk("w_idle_done",  32'(p0_done),    32'h0);
        chk("w_idle_busy",  32'(busy),       32'h0);
        chk("w_idle_wr",    32'(mem_write),  32'h0);
        chk("w_ram",        ram[16],         32'hDEAD_BEEF);

        // Port 0 read back 0x010
        p0_we = 1'b0; p0_req = 1'b1;
        step();
        p0_req = 1'b0;
        chk("r_setup_rd",   32'(mem_read),   32'h1);
        step();
        chk("r_strobe_done",32'(p0_done),    32'h0);
        step();
        chk("r_cap_done",   32'(p0_done),    32'h1);
        chk("r_cap_data",   p0_rdata,        32'hDEAD_BEEF);
        step();
        chk("r_idle_rd",    32'(mem_read),   32'h0);

        // Simultaneous requests after a fresh reset
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr2_busy", 32'(busy), 32'h0);
        fp = c_RR ? 0 : 1;
        p0_we = 1'b0; p0_addr = 9'h001; p1_we = 1'b0; p1_addr = 9'h002;
        p0_req = 1'b1; p1_req = 1'b1;
        step();
        chk("arb_grant1", 32'(grant), 32'(fp));
        if (fp == 1) p1_req = 1'b0; else p0_req = 1'b0;
        step();
        step();
        chk("arb_p0done1", 32'(p0_done), 32'(fp == 0));
        chk("arb_p1done1", 32'(p1_done), 32'(fp == 1));
        chk("arb_data1", (fp == 1) ? p1_rdata : p0_rdata, (fp == 1) ? 32'h1111_0002 : 32'h1111_0001);
        step();
        chk("arb_grant2", 32'(grant), 32'(1 - fp));
        p0_req = 1'b0; p1_req = 1'b0;
        step();
        step();
        chk("arb_p0done2", 32'(p0_done), 32'(fp == 1));
        chk("arb_p1done2", 32'(p1_done), 32'(fp == 0));
        chk("arb_data2", (fp == 1) ? p0_rdata : p1_rdata, (fp == 1) ? 32'h1111_0001 : 32'h1111_0002);
        step();

        // Port 1 back-to-back reads of 0x000..0x003 with req held high
        p1_we = 1'b0; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p1_addr = 9'(i);
            step();
            if (i == 3) p1_req = 1'b0;
            chk("b2b_addr",  32'(mem_addr), 32'(i));
            chk("b2b_done0", 32'(p1_done),  32'h0);
            step();
            chk("b2b_done1", 32'(p1_done),  32'h0);
            step();
            chk("b2b_done",  32'(p1_done),  32'h1);
            chk("b2b_data",  p1_rdata,      32'h1111_0000 + 32'(i));
        end
        step();
        chk("b2b_idle_busy", 32'(busy),    32'h0);
        chk("b2b_idle_done", 32'(p1_done), 32'h0);

        // Requester address changes during STROBE must not affect the access
        p0_we = 1'b0; p0_addr = 9'h005; p0_req = 1'b1;
        step();
        p0_req = 1'b0;
        step();
        p0_addr = 9'h1FF;
        chk("hold_en",   32'(mem_enable), 32'h1);
        step();
        chk("hold_addr", 32'(mem_addr),   32'h005);
        chk("hold_done", 32'(p0_done),    32'h1);
        chk("hold_data", p0_rdata,        32'h5555_AAAA);
        step();

        // clr during STROBE of a read
        p0_req = 1'b1;
        step();
        p0_req = 1'b0;
        step();
        chk("abort_en", 32'(mem_enable), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("abort_busy",  32'(busy),       32'h0);
        chk("abort_en0",   32'(mem_enable), 32'h0);
        chk("abort_rd",    32'(mem_read),   32'h0);
        chk("abort_addr",  32'(mem_addr),   32'h0);
        chk("abort_din",   mem_datain,      32'h0);
        chk("abort_grant", 32'(grant),      32'h0);
        chk("abort_p0rd",  p0_rdata,        32'h0);
        chk("abort_p1rd",  p1_rdata,        32'h0);
        chk("abort_done",  32'(p0_done),    32'h0);
        step();
        chk("abort_done2", 32'(p0_done),    32'h0);
        chk("abort_busy2", 32'(busy),       32'h0);
        step();

        chk("en_count", 32'(en_cnt), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of the RAM data bus.
REQ-002 SHALL have parameter ADDR_SPACE, default 9, RAM address width (512 words).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port clr, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports p0_req/p1_req, input, 1, access request (port 0 = instruction fetch, port 1 = data).
REQ-006 SHALL have ports p0_we/p1_we, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have ports p0_addr/p1_addr, input, ADDR_SPACE, word address.
REQ-008 SHALL have ports p0_wdata/p1_wdata, input, DATA_WIDTH, write data.
REQ-009 SHALL have ports p0_done/p1_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports p0_rdata/p1_rdata, output, DATA_WIDTH, read result, valid while the matching done is high.
REQ-011 SHALL have ports mem_addr (ADDR_SPACE), mem_datain (DATA_WIDTH), mem_read, mem_write, mem_enable (1 each), outputs, to the RAM.
REQ-012 SHALL have port mem_dataout, input, DATA_WIDTH, RAM read data.
REQ-013 SHALL have ports busy (1) and grant (1, 0 = port 0, 1 = port 1), outputs.

Function
REQ-014 SHALL implement states IDLE, SETUP, STROBE, CAPTURE.
REQ-015 SHALL, in IDLE or CAPTURE with any req high, arbitrate, register the winner's we/addr/wdata into mem_* and grant, and enter SETUP; otherwise enter or stay in IDLE.
REQ-016 SHALL, in SETUP, drive mem_enable=0 with mem_addr, mem_datain and {mem_read,mem_write} (10 read, 01 write) stable, then enter STROBE.
REQ-017 SHALL, in STROBE, drive mem_enable=1 for exactly one cycle with all other mem_* unchanged, then enter CAPTURE.
REQ-018 SHALL, on the edge leaving STROBE, register mem_dataout into the granted port's rdata for reads; rdata holds its last value otherwise.
REQ-019 SHALL, in CAPTURE, drive mem_enable=0 and pulse the granted port's done for that one cycle only.
REQ-020 Latency: req high at IDLE edge k SHALL give done high in cycle k+3; back-to-back accesses SHALL complete every 3 cycles.
REQ-021 SHALL sample requester fields only at grant; changes before done SHALL NOT affect the access in flight.
REQ-022 SHALL complete a granted access and pulse done even if req drops before done.
REQ-023 Fixed priority (macro absent): simultaneous requests SHALL grant port 1.
REQ-024 busy SHALL be 1 in SETUP, STROBE, CAPTURE; 0 in IDLE.
REQ-025 mem_read and mem_write SHALL never both be 1; in IDLE both SHALL be 0.

Reset
REQ-026 clr high at a rising edge SHALL force IDLE and all outputs to 0 (mem_*, done, rdata, busy, grant), with priority over all transitions.
REQ-027 clr during STROBE SHALL drop mem_enable next edge; a write already strobed MAY have landed, and no done SHALL be issued.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined SHALL select round-robin: on simultaneous requests, grant the port not granted last (port 0 first after reset).
REQ-029 Without ARB_ROUND_ROBIN_EN, fixed priority per REQ-023 SHALL apply, and port 0 may starve.

Verification
REQ-030 Port 0 write addr 0x010 data 0xDEADBEEF, then read 0x010 -> p0_done at k+3 each; read returns p0_rdata=0xDEADBEEF.
REQ-031 Both req high in IDLE, port 0 read 0x001, port 1 read 0x002 -> p1_done first, p0_done 3 cycles later (fixed); with ARB_ROUND_ROBIN_EN, p0_done first.
REQ-032 Port 1 req held high for 4 reads of 0x000-0x003 -> p1_done at cycles k+3, k+6, k+9, k+12 with matching data.
REQ-033 Change p0_addr 0x005->0x1FF in STROBE -> read returns contents of 0x005.
REQ-034 clr asserted in STROBE of a read -> next cycle IDLE, all outputs 0, no done.
REQ-035 Bench checks every cycle: mem_enable high exactly one cycle per access, never both mem_read and mem_write.
